// File: rtl/line_memory_responder_pkg.sv
// Shared types and helpers for the 256-bit line memory responder.
// Holds the FSM state encoding and the byte-address to line-index mapping.
package line_memory_responder_pkg;

  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;
  localparam int MAX_ADDR_W  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Drops the byte offset and keeps idx_w index bits, so addresses wrap per line count.
  function automatic logic [MAX_ADDR_W-1:0] line_index(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int idx_w);
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << idx_w) - MAX_ADDR_W'(1);
    return (addr >> OFFSET_BITS) & mask;
  endfunction

endpackage

// File: rtl/line_memory_responder_line_ram.sv
// Single-port line storage: synchronous write, registered read.
// The read register resets to zero so the read port is never X; the array itself is not cleared.
module line_ram #(
  parameter  int DEPTH_LINES = 512,
  parameter  int LINE_W      = 256,
  localparam int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH_LINES];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory_responder.sv
// Fixed-latency slave for the cache's line enable/write/addr/data/ack handshake.
// One request at a time: accept in IDLE, count down in WAIT, pulse ack for one ACK cycle.
module line_memory_responder #(
  parameter int LATENCY     = 10,
  parameter int DEPTH_LINES = 512,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = line_memory_responder_pkg::LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_enable_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_ack_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              busy_o
);
  import line_memory_responder_pkg::*;

  localparam int         IDX_W    = $clog2(DEPTH_LINES);
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              ack_q;
  logic              busy_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic [LINE_W-1:0] wdata_q;

  logic              accept;
  logic              enter_ack;
  logic              wr_now;
  logic [IDX_W-1:0]  idx_in;
  logic [IDX_W-1:0]  ram_idx;
  logic [LINE_W-1:0] ram_wdata;

  assign idx_in    = IDX_W'(line_index(MAX_ADDR_W'(mem_addr_i), IDX_W));
  assign accept    = (state_q == IDLE) && mem_enable_i;
  assign enter_ack = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 8'd1));

  // With LATENCY=1 the RAM is accessed on the accepting edge, before the latches are loaded.
  assign wr_now    = (state_q == IDLE) ? mem_write_i : wr_q;
  assign ram_idx   = (state_q == IDLE) ? idx_in      : idx_q;
  assign ram_wdata = (state_q == IDLE) ? mem_data_i  : wdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_enable_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_LOAD;
            if (enter_ack) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 8'd1;
          if (enter_ack) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q   <= idx_in;
      wr_q    <= mem_write_i;
      wdata_q <= mem_data_i;
    end
  end

  line_ram #(
    .DEPTH_LINES(DEPTH_LINES),
    .LINE_W     (LINE_W)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (enter_ack & wr_now),
    .re_i   (enter_ack & ~wr_now),
    .idx_i  (ram_idx),
    .wdata_i(ram_wdata),
    .rdata_o(mem_data_o)
  );

  assign mem_ack_o = ack_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench with a scoreboard for two responder instances (LATENCY=10 and LATENCY=1).
module tb_line_memory_responder;

  typedef struct packed {
    logic         wr;
    logic [255:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_en = 1'b0, a_wr = 1'b0;
  logic [31:0]  a_addr = '0;
  logic [255:0] a_wdata = '0;
  logic         a_ack, a_busy;
  logic [255:0] a_rdata;

  logic         b_en = 1'b0, b_wr = 1'b0;
  logic [31:0]  b_addr = '0;
  logic [255:0] b_wdata = '0;
  logic         b_ack, b_busy;
  logic [255:0] b_rdata;

  line_memory_responder #(.LATENCY(10), .DEPTH_LINES(512), .ADDR_W(32), .LINE_W(256)) u_a (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(a_en), .mem_write_i(a_wr), .mem_addr_i(a_addr),
    .mem_data_i(a_wdata), .mem_ack_o(a_ack), .mem_data_o(a_rdata), .busy_o(a_busy)
  );

  line_memory_responder #(.LATENCY(1), .DEPTH_LINES(512), .ADDR_W(32), .LINE_W(256)) u_b (
    .clk_i(clk), .rst_i(rst), .mem_enable_i(b_en), .mem_write_i(b_wr), .mem_addr_i(b_addr),
    .mem_data_i(b_wdata), .mem_ack_o(b_ack), .mem_data_o(b_rdata), .busy_o(b_busy)
  );

  exp_t         qa[$];
  exp_t         qb[$];
  logic [255:0] mdl_a [512];
  logic [255:0] mdl_b [512];
  logic [255:0] last_a = '0;
  logic [255:0] last_b = '0;
  int checks = 0;
  int failures = 0;

  logic         op_wr   [6];
  logic [31:0]  op_addr [6];
  logic [255:0] op_data [6];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lidx(input logic [31:0] addr);
    return int'((addr >> 5) & 32'd511);
  endfunction

  task automatic push_a(input logic wr, input logic [31:0] addr, input logic [255:0] d);
    exp_t e;
    e.wr = wr;
    if (wr) begin
      mdl_a[lidx(addr)] = d;
      e.data = last_a;
    end else begin
      e.data = mdl_a[lidx(addr)];
      last_a = e.data;
    end
    qa.push_back(e);
  endtask

  task automatic push_b(input logic wr, input logic [31:0] addr, input logic [255:0] d);
    exp_t e;
    e.wr = wr;
    if (wr) begin
      mdl_b[lidx(addr)] = d;
      e.data = last_b;
    end else begin
      e.data = mdl_b[lidx(addr)];
      last_b = e.data;
    end
    qb.push_back(e);
  endtask

  // Issues one request on instance A; optionally scrambles the inputs while it is waiting.
  task automatic req_a(input logic wr, input logic [31:0] addr, input logic [255:0] d,
                       input bit scramble, input string tag);
    int   n;
    exp_t e;
    a_en = 1'b1; a_wr = wr; a_addr = addr; a_wdata = d;
    push_a(wr, addr, d);
    @(posedge clk); #1;
    a_en = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (a_ack || n > 40) break;
      if (scramble) begin
        a_en = 1'($urandom); a_wr = 1'($urandom);
        a_addr = $urandom; a_wdata = {8{$urandom}};
      end
    end
    a_en = 1'b0;
    chk({tag, "_latency"}, 256'(n), 256'(10));
    chk({tag, "_busy_in_ack"}, 256'(a_busy), 256'(1));
    e = qa.pop_front();
    chk({tag, "_data"}, a_rdata, e.data);
    @(negedge clk);
    chk({tag, "_ack_fall"}, 256'(a_ack), 256'(0));
    chk({tag, "_busy_fall"}, 256'(a_busy), 256'(0));
  endtask

  task automatic count_idle_acks_a(input int cycles, input string tag);
    int acks;
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (a_ack) acks++;
    end
    chk(tag, 256'(acks), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    exp_t e;
    logic [255:0] v;

    for (int i = 0; i < 512; i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 256'(a_ack), 256'(0));
    chk("rst_data", a_rdata, 256'(0));
    chk("rst_busy", 256'(a_busy), 256'(0));
    chk("rst_b_data", b_rdata, 256'(0));
    rst = 1'b0;

    v = {32{8'hA5}};
    u_a.u_ram.mem_q[3] = v; mdl_a[3] = v;
    v = 256'hFF;
    u_a.u_ram.mem_q[7] = v; mdl_a[7] = v;

    count_idle_acks_a(3, "idle_no_ack");
    chk("idle_busy", 256'(a_busy), 256'(0));

    req_a(1'b0, 32'h60, '0, 1'b0, "rd_line3");
    req_a(1'b1, 32'h80, 256'h1234, 1'b0, "wr_80");
    req_a(1'b0, 32'h80, '0, 1'b0, "rd_80");
    req_a(1'b1, 32'h4020, {4{64'hBEEF_0000_1111_2222}}, 1'b0, "wr_wrap");
    req_a(1'b0, 32'h20, '0, 1'b0, "rd_wrap");

    req_a(1'b1, 32'hA0, {8{32'hCAFE_F00D}}, 1'b1, "wr_scramble");
    count_idle_acks_a(15, "wr_scramble_one_ack");
    req_a(1'b0, 32'h20, '0, 1'b1, "rd_scramble");
    count_idle_acks_a(15, "rd_scramble_one_ack");
    req_a(1'b0, 32'hA0, '0, 1'b0, "rd_scramble_line");

    // Abort a write to line 7 four cycles after acceptance.
    a_en = 1'b1; a_wr = 1'b1; a_addr = 32'hE0; a_wdata = 256'hDEAD;
    @(posedge clk); #1;
    a_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_ack", 256'(a_ack), 256'(0));
    chk("abort_data", a_rdata, 256'(0));
    chk("abort_busy", 256'(a_busy), 256'(0));
    @(posedge clk); #1 rst = 1'b0;
    last_a = '0;
    last_b = '0;
    count_idle_acks_a(15, "abort_no_ack");
    req_a(1'b0, 32'hE0, '0, 1'b0, "rd_line7_after_abort");

    // LATENCY=1 instance with enable held high throughout.
    for (int i = 0; i < 6; i++) begin
      v = {8{32'(i) * 32'h1111 + 32'd7}};
      u_b.u_ram.mem_q[i] = v; mdl_b[i] = v;
    end
    op_wr[0] = 1'b0; op_addr[0] = 32'h00;  op_data[0] = '0;
    op_wr[1] = 1'b0; op_addr[1] = 32'h20;  op_data[1] = '0;
    op_wr[2] = 1'b1; op_addr[2] = 32'h140; op_data[2] = {4{64'h0123_4567_89AB_CDEF}};
    op_wr[3] = 1'b0; op_addr[3] = 32'h40;  op_data[3] = '0;
    op_wr[4] = 1'b0; op_addr[4] = 32'h140; op_data[4] = '0;
    op_wr[5] = 1'b0; op_addr[5] = 32'hA0;  op_data[5] = '0;

    @(negedge clk);
    k = 0;
    b_en = 1'b1; b_wr = op_wr[0]; b_addr = op_addr[0]; b_wdata = op_data[0];
    push_b(op_wr[0], op_addr[0], op_data[0]);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("lat1_ack_c%0d", i), 256'(b_ack), 256'((i % 2) == 0));
      if (b_ack) begin
        e = qb.pop_front();
        chk($sformatf("lat1_data_op%0d", k), b_rdata, e.data);
        k++;
        if (k < 6) begin
          b_wr = op_wr[k]; b_addr = op_addr[k]; b_wdata = op_data[k];
          push_b(op_wr[k], op_addr[k], op_data[k]);
        end else begin
          b_en = 1'b0;
        end
      end
    end
    chk("lat1_ack_count", 256'(k), 256'(6));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_memory_responder.md
Name: line_memory_responder

Overview:
- Off-chip main-memory responder for the data cache's 256-bit line interface. It is the slave end of the enable/write/addr/data/ack handshake that the cache drives.
- Accepts one line read or line write at a time and waits a fixed programmable latency. It then pulses ack for one cycle; read data is valid in that same cycle.
- Sits beside the CPU in the testbench/top level and connects directly to the cache's memory ports.

Parameters:
- LATENCY, 10, cycles from request acceptance to ack; legal range 1..255
- DEPTH_LINES, 512, number of 256-bit lines stored; power of two
- ADDR_W, 32, byte-address width
- LINE_W, 256, line width in bits

Ports:
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  asynchronous, active-high reset
- mem_enable_i  input  1  request valid; sampled only in IDLE
- mem_write_i  input  1  1 = line write, 0 = line read; sampled with enable
- mem_addr_i  input  ADDR_W  byte address; bits [4:0] ignored
- mem_data_i  input  LINE_W  write line; sampled with enable
- mem_ack_o  output  1  one-cycle completion pulse
- mem_data_o  output  LINE_W  read line; valid while mem_ack_o=1 after a read
- busy_o  output  1  high from acceptance through the ack cycle

Behaviour:
- Reset (async, immediate):
  - state=IDLE, counter=0, mem_ack_o=0, mem_data_o=0, busy_o=0.
  - Array contents are not cleared; the bench preloads them by hierarchical access.
- Line index = mem_addr_i[log2(DEPTH_LINES)+4:5]. Address bits above the index are ignored, so addresses wrap modulo DEPTH_LINES lines.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on an edge with mem_enable_i=1, latch index, write flag and data. Counter loads LATENCY-1. Go to WAIT, or directly to ACK if LATENCY=1. busy_o=1 from that edge.
  - WAIT: counter decrements each edge; when counter==1 at an edge, go to ACK. Changes on the inputs while in WAIT are ignored.
  - ACK:
    - mem_ack_o=1 for exactly this one cycle.
    - Read: mem_data_o = array[latched index], registered on the edge entering ACK.
    - Write: array[latched index] is written on the edge entering ACK. mem_data_o holds its previous value.
    - The next edge returns to IDLE unconditionally. mem_enable_i is not sampled in ACK.
- Latency: a request accepted at edge T gives mem_ack_o high in the cycle after edge T+LATENCY-1. Ack is therefore visible to the cache at edge T+LATENCY.
- Back-to-back: the earliest next acceptance is the edge following the ACK cycle (IDLE cycle). Example: a write-back followed by an allocate read gives two ack pulses separated by at least LATENCY+1 cycles.
- mem_data_o holds the last read line until the next read ack; it is never X after reset.
- Reset asserted in WAIT: the request is aborted, the write is not committed and no ack is issued.
- Read of a line written earlier returns the new data.
- Enable low in IDLE: stays in IDLE with no side effects.

Decomposition:
- Shared package:
  - LINE_W, OFFSET_BITS=5
  - state enum {IDLE, WAIT, ACK}
  - line_index function (addr -> index)
- One sub-module: line_ram.
  - DEPTH_LINES x LINE_W array.
  - Synchronous write enable, registered read, one port.
  - The FSM drives it in the ACK-entry cycle.

Test Plan:
- Reset, then preload line 3 with 256'hA5..A5. Read addr 0x60 at edge T (LATENCY=10) -> ack high only in the cycle after edge T+9, mem_data_o=A5..A5, busy_o falls after ack.
- Write 256'h1234 to addr 0x80, then read addr 0x80 -> two single-cycle acks; the read returns 256'h1234; mem_data_o is unchanged during the write ack.
- Address wrap: DEPTH_LINES=512. Write addr 0x4020 (index 1 after wrap), then read addr 0x20 -> returns the written data.
- Change addr and data every cycle while in WAIT -> the result uses the values latched at acceptance; exactly one ack.
- Assert rst_i 4 cycles into a write to line 7 (old data 0xFF) -> no ack; a later read of line 7 returns 0xFF; after reset mem_ack_o=0 and mem_data_o=0.
- LATENCY=1 with enable held high continuously -> acks on every other cycle (accept, ACK, accept, ACK ...); each request is serviced exactly once.
